// File: rtl/plic_pkg.sv
// Shared PLIC types and sizes: source count, ID width and gateway cell enums.
package plic_pkg;

    localparam int unsigned NUM_SOURCES     = 6;
    localparam int unsigned SOURCE_ID_WIDTH = $clog2(NUM_SOURCES + 1);

    typedef enum logic [1:0] {
        GW_IDLE,
        GW_REQ,
        GW_INFLIGHT
    } gw_state_e;

    typedef enum logic {
        GW_LEVEL = 1'b0,
        GW_EDGE  = 1'b1
    } gw_mode_e;

endpackage

// File: rtl/plic_gateway_cell.sv
// One interrupt source gateway: request FSM, saturating edge counter, overflow flag.
// PLIC_GATEWAY_SYNC_EN adds a 2-flop input synchronizer ahead of the edge/level logic.
module plic_gateway_cell
    import plic_pkg::*;
#(
    parameter int unsigned EDGE_CNT_W = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_src,
    input  logic i_edge_mode,
    input  logic i_claim,
    input  logic i_complete,
    output logic o_ip,
    output logic o_inflight,
    output logic o_overflow
);

    localparam logic [EDGE_CNT_W-1:0] CntMax = '1;
    localparam logic [EDGE_CNT_W-1:0] CntOne = EDGE_CNT_W'(1);

    gw_state_e             r_state, w_state_next;
    logic [EDGE_CNT_W-1:0] r_cnt, w_cnt_next;
    logic                  r_prev;
    logic                  r_ovf, w_ovf_next;
    logic                  w_src;
    gw_mode_e              w_mode;
    logic                  w_rise;
    logic                  w_claim_ok;
    logic                  w_complete_ok;
    logic                  w_req_avail;

`ifdef PLIC_GATEWAY_SYNC_EN
    logic r_sync1, r_sync2;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_src;
            r_sync2 <= r_sync1;
        end
    end

    assign w_src = r_sync2;
`else
    assign w_src = i_src;
`endif

    assign w_mode        = gw_mode_e'(i_edge_mode);
    assign w_rise        = w_src & ~r_prev;
    // Claims/completes only count when legal for the current state.
    assign w_claim_ok    = i_claim && (r_state == GW_REQ);
    assign w_complete_ok = i_complete && (r_state == GW_INFLIGHT);
    assign w_req_avail   = (w_mode == GW_EDGE) ? ((r_cnt != '0) || w_rise) : w_src;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            GW_IDLE:     if (w_req_avail) w_state_next = GW_REQ;
            GW_REQ:      if (w_claim_ok) w_state_next = GW_INFLIGHT;
            GW_INFLIGHT: if (w_complete_ok) w_state_next = GW_IDLE;
            default:     w_state_next = GW_IDLE;
        endcase
    end

    // Edge and claim together leave the count unchanged, even at saturation.
    always_comb begin
        w_cnt_next = r_cnt;
        w_ovf_next = r_ovf;
        if (w_mode == GW_LEVEL) begin
            w_cnt_next = '0;
        end else if (w_rise && !w_claim_ok) begin
            if (r_cnt == CntMax) begin
                w_ovf_next = 1'b1;
            end else begin
                w_cnt_next = r_cnt + CntOne;
            end
        end else if (!w_rise && w_claim_ok && (r_cnt != '0)) begin
            w_cnt_next = r_cnt - CntOne;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= GW_IDLE;
            r_cnt   <= '0;
            r_prev  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_prev  <= w_src;
            r_ovf   <= w_ovf_next;
        end
    end

    assign o_ip       = (r_state == GW_REQ);
    assign o_inflight = (r_state == GW_INFLIGHT);
    assign o_overflow = r_ovf;

endmodule

// File: rtl/plic_gateway.sv
// PLIC gateway array: one cell per source 1..NUM_SOURCES plus claim/complete ID decode.
// Optional input synchronizers are enabled with PLIC_GATEWAY_SYNC_EN.
module plic_gateway
    import plic_pkg::*;
#(
    parameter int unsigned NUM_SOURCES = plic_pkg::NUM_SOURCES,
    parameter int unsigned EDGE_CNT_W  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_SOURCES:0]       src_i,
    input  logic [NUM_SOURCES:0]       edge_mode_i,
    input  logic                       claim_valid_i,
    input  logic [SOURCE_ID_WIDTH-1:0] claim_id_i,
    input  logic                       complete_valid_i,
    input  logic [SOURCE_ID_WIDTH-1:0] complete_id_i,
    output logic [NUM_SOURCES:0]       ip_o,
    output logic [NUM_SOURCES:0]       inflight_o,
    output logic [NUM_SOURCES:0]       overflow_o
);

    // ID 0 is reserved: its input bits are intentionally unused.
    logic w_unused_id0;
    assign w_unused_id0 = src_i[0] ^ edge_mode_i[0];

    assign ip_o[0]       = 1'b0;
    assign inflight_o[0] = 1'b0;
    assign overflow_o[0] = 1'b0;

    for (genvar k = 1; k <= int'(NUM_SOURCES); k++) begin : g_cell
        logic w_claim;
        logic w_complete;

        // Out-of-range IDs never match any cell and are dropped here.
        assign w_claim    = claim_valid_i && (claim_id_i == SOURCE_ID_WIDTH'(k));
        assign w_complete = complete_valid_i && (complete_id_i == SOURCE_ID_WIDTH'(k));

        plic_gateway_cell #(
            .EDGE_CNT_W(EDGE_CNT_W)
        ) u_cell (
            .i_clk      (clk),
            .i_reset    (reset),
            .i_src      (src_i[k]),
            .i_edge_mode(edge_mode_i[k]),
            .i_claim    (w_claim),
            .i_complete (w_complete),
            .o_ip       (ip_o[k]),
            .o_inflight (inflight_o[k]),
            .o_overflow (overflow_o[k])
        );
    end

endmodule

// File: tb/tb_plic_gateway.sv
// Self-checking bench for plic_gateway: directed scenarios plus random traffic
// compared against a pending/claimed/edge-count reference model.
module tb_plic_gateway;

    localparam int NS   = 6;
    localparam int CMAX = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NS:0]   src_i = '0;
    logic [NS:0]   edge_mode_i = '0;
    logic          claim_valid_i = 1'b0;
    logic [2:0]    claim_id_i = '0;
    logic          complete_valid_i = 1'b0;
    logic [2:0]    complete_id_i = '0;
    logic [NS:0]   ip_o, inflight_o, overflow_o;

    int n_checks = 0;
    int n_errors = 0;

    bit m_ip[NS+1], m_infl[NS+1], m_ovf[NS+1], m_prev[NS+1];
    int m_cnt[NS+1];
    bit n_ip[NS+1], n_infl[NS+1], n_ovf[NS+1], n_prev[NS+1];
    int n_cnt[NS+1];

    plic_gateway dut (
        .clk             (clk),
        .reset           (reset),
        .src_i           (src_i),
        .edge_mode_i     (edge_mode_i),
        .claim_valid_i   (claim_valid_i),
        .claim_id_i      (claim_id_i),
        .complete_valid_i(complete_valid_i),
        .complete_id_i   (complete_id_i),
        .ip_o            (ip_o),
        .inflight_o      (inflight_o),
        .overflow_o      (overflow_o)
    );

    always #5 clk = ~clk;

    // Reference: a source is pending or claimed; edges are counted as outstanding requests.
    function automatic void model_step();
        for (int k = 1; k <= NS; k++) begin
            bit s, em, rise, clm, cmp, avail;
            int cnt;
            if (reset) begin
                n_ip[k] = 0; n_infl[k] = 0; n_ovf[k] = 0; n_prev[k] = 0; n_cnt[k] = 0;
            end else begin
                s     = src_i[k];
                em    = edge_mode_i[k];
                rise  = s && !m_prev[k];
                clm   = claim_valid_i && (int'(claim_id_i) == k) && m_ip[k];
                cmp   = complete_valid_i && (int'(complete_id_i) == k) && m_infl[k];
                avail = em ? (m_cnt[k] > 0 || rise) : s;
                cnt   = em ? m_cnt[k] + int'(rise) - int'(clm) : 0;
                n_ovf[k] = m_ovf[k];
                if (cnt > CMAX) begin
                    cnt = CMAX;
                    n_ovf[k] = 1;
                end
                if (cnt < 0) cnt = 0;
                n_cnt[k]  = cnt;
                n_ip[k]   = m_ip[k] ? !clm : (!m_infl[k] && avail);
                n_infl[k] = m_infl[k] ? !cmp : clm;
                n_prev[k] = s;
            end
        end
    endfunction

    function automatic logic [3*(NS+1)-1:0] model_vec();
        logic [NS:0] a, b, c;
        a = '0; b = '0; c = '0;
        for (int k = 1; k <= NS; k++) begin
            a[k] = m_ip[k]; b[k] = m_infl[k]; c[k] = m_ovf[k];
        end
        return {a, b, c};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        for (int k = 1; k <= NS; k++) begin
            m_ip[k] = n_ip[k]; m_infl[k] = n_infl[k]; m_ovf[k] = n_ovf[k];
            m_prev[k] = n_prev[k]; m_cnt[k] = n_cnt[k];
        end
    endtask

    task automatic do_claim(input int id);
        claim_valid_i = 1'b1; claim_id_i = 3'(id);
        tick();
        claim_valid_i = 1'b0;
    endtask

    task automatic do_complete(input int id);
        complete_valid_i = 1'b1; complete_id_i = 3'(id);
        tick();
        complete_valid_i = 1'b0;
    endtask

    task automatic pulse(input int k);
        src_i[k] = 1'b1; tick();
        src_i[k] = 1'b0; tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        n_checks++;
        if ({ip_o, inflight_o, overflow_o} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %h want 0", {ip_o, inflight_o, overflow_o});
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if ({ip_o, inflight_o, overflow_o} !== model_vec()) begin
            n_errors++;
            $display("FAIL reset_release: got %h want %h", {ip_o, inflight_o, overflow_o},
                     model_vec());
        end
    endtask

    task automatic test_level();
        src_i[3] = 1'b1;
        tick();
        n_checks++;
        if (ip_o[3] !== 1'b1) begin
            n_errors++; $display("FAIL level_ip: got %b want 1", ip_o[3]);
        end
        do_claim(3);
        n_checks++;
        if ({ip_o[3], inflight_o[3]} !== 2'b01) begin
            n_errors++; $display("FAIL level_claim: got %b want 01", {ip_o[3], inflight_o[3]});
        end
        do_complete(3);
        n_checks++;
        if ({ip_o[3], inflight_o[3]} !== 2'b00) begin
            n_errors++; $display("FAIL level_complete: got %b want 00", {ip_o[3], inflight_o[3]});
        end
        tick();
        n_checks++;
        if (ip_o[3] !== 1'b1) begin
            n_errors++; $display("FAIL level_rereq: got %b want 1", ip_o[3]);
        end
        src_i[3] = 1'b0;
        do_claim(3);
        do_complete(3);
        tick();
        n_checks++;
        if ({ip_o, inflight_o, overflow_o} !== model_vec()) begin
            n_errors++;
            $display("FAIL level_model: got %h want %h", {ip_o, inflight_o, overflow_o},
                     model_vec());
        end
    endtask

    task automatic test_edge_rounds();
        edge_mode_i[2] = 1'b1;
        pulse(2); pulse(2); pulse(2);
        for (int r = 0; r < 3; r++) begin
            n_checks++;
            if (ip_o[2] !== 1'b1) begin
                n_errors++; $display("FAIL edge_round%0d_ip: got %b want 1", r, ip_o[2]);
            end
            do_claim(2);
            do_complete(2);
            tick();
        end
        n_checks++;
        if ({ip_o[2], overflow_o[2]} !== 2'b00) begin
            n_errors++; $display("FAIL edge_drained: got %b want 00", {ip_o[2], overflow_o[2]});
        end
    endtask

    task automatic test_overflow();
        int rounds;
        edge_mode_i[1] = 1'b1;
        for (int i = 0; i < 5; i++) pulse(1);
        n_checks++;
        if (overflow_o[1] !== 1'b1) begin
            n_errors++; $display("FAIL ovf_flag: got %b want 1", overflow_o[1]);
        end
        rounds = 0;
        for (int i = 0; i < 6; i++) begin
            if (ip_o[1] === 1'b1) begin
                do_claim(1); do_complete(1); tick();
                rounds++;
            end
        end
        n_checks++;
        if (rounds !== 3) begin
            n_errors++; $display("FAIL ovf_rounds: got %0d want 3", rounds);
        end
    endtask

    task automatic test_edge_claim_same();
        edge_mode_i[4] = 1'b1;
        pulse(4);
        src_i[4] = 1'b1;
        do_claim(4);
        src_i[4] = 1'b0;
        n_checks++;
        if ({ip_o[4], inflight_o[4]} !== 2'b01) begin
            n_errors++; $display("FAIL same_claim: got %b want 01", {ip_o[4], inflight_o[4]});
        end
        tick();
        do_complete(4);
        tick();
        n_checks++;
        if (ip_o[4] !== 1'b1) begin
            n_errors++; $display("FAIL same_rereq: got %b want 1", ip_o[4]);
        end
        do_claim(4); do_complete(4); tick();
        n_checks++;
        if ({ip_o, inflight_o, overflow_o} !== model_vec()) begin
            n_errors++;
            $display("FAIL same_model: got %h want %h", {ip_o, inflight_o, overflow_o},
                     model_vec());
        end
    endtask

    task automatic test_illegal_ids();
        do_claim(0);
        do_claim(7);
        do_complete(5);
        n_checks++;
        if ({ip_o[5], inflight_o[5]} !== 2'b00) begin
            n_errors++; $display("FAIL illegal_src5: got %b want 00", {ip_o[5], inflight_o[5]});
        end
        n_checks++;
        if ({ip_o, inflight_o, overflow_o} !== model_vec()) begin
            n_errors++;
            $display("FAIL illegal_model: got %h want %h", {ip_o, inflight_o, overflow_o},
                     model_vec());
        end
    endtask

    task automatic test_reset_midop();
        edge_mode_i[6] = 1'b1;
        pulse(6); pulse(6); pulse(6);
        do_claim(6);
        n_checks++;
        if (inflight_o[6] !== 1'b1) begin
            n_errors++; $display("FAIL midop_inflight: got %b want 1", inflight_o[6]);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if ({ip_o, inflight_o, overflow_o} !== '0) begin
            n_errors++;
            $display("FAIL midop_reset: got %h want 0", {ip_o, inflight_o, overflow_o});
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (ip_o[6] !== 1'b0) begin
                n_errors++; $display("FAIL midop_after%0d: got %b want 0", i, ip_o[6]);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int k = 1; k <= NS; k++) begin
                if ($urandom_range(0, 3) == 0) src_i[k] = ~src_i[k];
                if ($urandom_range(0, 31) == 0) edge_mode_i[k] = ~edge_mode_i[k];
            end
            src_i[0]         = 1'($urandom);
            claim_valid_i    = ($urandom_range(0, 2) == 0);
            claim_id_i       = 3'($urandom_range(0, 7));
            complete_valid_i = ($urandom_range(0, 2) == 0);
            complete_id_i    = 3'($urandom_range(0, 7));
            reset            = ($urandom_range(0, 199) == 0);
            tick();
            n_checks++;
            if ({ip_o, inflight_o, overflow_o} !== model_vec()) begin
                n_errors++;
                $display("FAIL random_c%0d: got %h want %h", c, {ip_o, inflight_o, overflow_o},
                         model_vec());
            end
        end
        reset = 1'b0; claim_valid_i = 1'b0; complete_valid_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_level();
        test_edge_rounds();
        test_overflow();
        test_edge_claim_same();
        test_illegal_ids();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
